demux_1_8_deser: RTL and testbench

- Serial-to-parallel companion to the team's 8:1 select mux. It routes one incoming bit per strobe into one of 8 word positions, chosen either by an explicit 3-bit select code or by an internal auto-incrementing counter.
- When all 8 positions have been written, it presents the assembled byte to a downstream consumer with a valid/ready handshake.
- It sits on the receive side of the same 8-bit datapath that the mux serializes.

---
 rtl/demux_pkg.sv | 28 ++
 rtl/demux_1_8_dec.sv | 15 +
 rtl/demux_1_8_deser.sv | 106 ++++++++++
 tb/tb_demux_1_8_deser.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants, output FSM states and auto-counter direction for demux_1_8_deser.
// Build option DEMUX_MSB_FIRST_EN: auto counter starts at 7 and counts down.
package demux_pkg;

  localparam int unsigned SEL_W  = 3;
  localparam int unsigned WORD_W = 8;
  localparam logic [WORD_W-1:0] MASK_FULL = 8'hFF;

  typedef enum logic [0:0] {
    ST_EMPTY,
    ST_HOLD
  } state_e;

`ifdef DEMUX_MSB_FIRST_EN
  localparam logic [SEL_W-1:0] CNT_START = 3'd7;

  function automatic logic [SEL_W-1:0] cnt_step(input logic [SEL_W-1:0] cnt);
    return cnt - 3'd1;
  endfunction
`else
  localparam logic [SEL_W-1:0] CNT_START = 3'd0;

  function automatic logic [SEL_W-1:0] cnt_step(input logic [SEL_W-1:0] cnt);
    return cnt + 3'd1;
  endfunction
`endif

endpackage

// File: rtl/demux_1_8_dec.sv
// 3-to-8 one-hot decoder with enable; per-bit write strobes for shadow and mask.
module demux_1_8_dec
  import demux_pkg::*;
(
  input  logic              en_i,
  input  logic [SEL_W-1:0]  sel_i,
  output logic [WORD_W-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/demux_1_8_deser.sv
// 1:8 bit demux / deserializer with valid/ready output and overflow flag.
// Build option DEMUX_MSB_FIRST_EN selects a down-counting auto index (see demux_pkg).
module demux_1_8_deser
  import demux_pkg::*;
#(
  parameter logic [WORD_W-1:0] RST_CODE   = 8'h00,
  parameter bit                OVF_STICKY = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_d,
  input  logic              i_bit_vld,
  input  logic              i_auto,
  input  logic [SEL_W-1:0]  i_sel_code,
  input  logic              i_rdy,
  output logic [WORD_W-1:0] o_code,
  output logic              o_vld,
  output logic [SEL_W-1:0]  o_sel_cur,
  output logic              o_ovf
);

  logic              accept;
  logic [SEL_W-1:0]  idx;
  logic [WORD_W-1:0] we;
  logic [WORD_W-1:0] shadow_q, shadow_d;
  logic [WORD_W-1:0] mask_q, mask_d, mask_set;
  logic [WORD_W-1:0] code_q, code_d;
  logic [SEL_W-1:0]  cnt_q, cnt_d;
  logic              complete;
  logic              drop;
  logic              ovf_q, ovf_d;
  state_e            state_q, state_d;

  assign accept = i_en & i_bit_vld;
  assign idx    = i_auto ? cnt_q : i_sel_code;

  demux_1_8_dec u_dec (
    .en_i     (accept),
    .sel_i    (idx),
    .onehot_o (we)
  );

  // Shadow collection runs independently of the output register.
  always_comb begin
    shadow_d = (shadow_q & ~we) | ({WORD_W{i_d}} & we);
    mask_set = mask_q | we;
    complete = accept & (mask_set == MASK_FULL);
    mask_d   = complete ? '0 : mask_set;
    cnt_d    = cnt_q;
    if (complete) begin
      cnt_d = CNT_START;
    end else if (accept && i_auto) begin
      cnt_d = cnt_step(cnt_q);
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    drop    = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (complete) begin
          state_d = ST_HOLD;
          code_d  = shadow_d;
        end
      end
      ST_HOLD: begin
        if (complete) begin
          // A word completing under backpressure is lost; the held word wins.
          if (i_rdy) code_d = shadow_d;
          else       drop   = 1'b1;
        end else if (i_rdy) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    ovf_d = OVF_STICKY ? (ovf_q | drop) : drop;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shadow_q <= '0;
      mask_q   <= '0;
      cnt_q    <= CNT_START;
      code_q   <= RST_CODE;
      state_q  <= ST_EMPTY;
      ovf_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      state_q  <= state_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_code    = code_q;
  assign o_vld     = (state_q == ST_HOLD);
  assign o_sel_cur = cnt_q;
  assign o_ovf     = ovf_q;

endmodule

// File: tb/tb_demux_1_8_deser.sv
// Scoreboard bench for demux_1_8_deser: expected words queued at stimulus, popped on handshake.
module tb_demux_1_8_deser;

`ifdef DEMUX_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       i_rst_n, i_en, i_d, i_bit_vld, i_auto, i_rdy;
  logic [2:0] i_sel_code;
  logic [7:0] o_code;
  logic       o_vld, o_ovf;
  logic [2:0] o_sel_cur;

  int tests = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_w;

  demux_1_8_deser dut (
    .i_clk      (clk),
    .i_rst_n    (i_rst_n),
    .i_en       (i_en),
    .i_d        (i_d),
    .i_bit_vld  (i_bit_vld),
    .i_auto     (i_auto),
    .i_sel_code (i_sel_code),
    .i_rdy      (i_rdy),
    .o_code     (o_code),
    .o_vld      (o_vld),
    .o_sel_cur  (o_sel_cur),
    .o_ovf      (o_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected auto counter value after k accepted bits of a word.
  function automatic logic [7:0] exp_sel(input int k);
    return MSB ? 8'(7 - k) : 8'(k);
  endfunction

  always @(negedge clk) begin
    if (i_rst_n && o_vld && i_rdy) begin
      if (exp_q.size() == 0) begin
        tests++;
        errors++;
        $display("FAIL unexpected_word: got %h expected none", o_code);
      end else begin
        exp_w = exp_q.pop_front();
        chk("scoreboard", o_code, exp_w);
      end
    end
  end

  task automatic strobe(input logic d, input logic a, input logic [2:0] s);
    i_d = d; i_auto = a; i_sel_code = s; i_bit_vld = 1'b1;
    @(posedge clk); #1;
    i_bit_vld = 1'b0;
  endtask

  // Auto-mode bits lo..hi of w, ordered so the assembled word equals w in either build.
  task automatic send_bits(input logic [7:0] w, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      strobe(w[MSB ? 7 - i : i], 1'b1, 3'd0);
    end
  endtask

  task automatic do_reset;
    i_rst_n = 1'b0; i_en = 1'b1; i_d = 1'b0; i_bit_vld = 1'b0;
    i_auto = 1'b1; i_sel_code = 3'd0; i_rdy = 1'b0;
    #7;
    @(posedge clk); #1;
    i_rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("rst_code", o_code, 8'h00);
    chk("rst_vld", {7'd0, o_vld}, 8'd0);
    chk("rst_ovf", {7'd0, o_ovf}, 8'd0);
    chk("rst_sel", {5'd0, o_sel_cur}, exp_sel(0));

    // Auto mode, always ready: 1,0,1,1,0,0,1,0 LSB first = 4D.
    i_rdy = 1'b1;
    exp_q.push_back(8'h4D);
    send_bits(8'h4D, 0, 2);
    chk("auto_sel_mid", {5'd0, o_sel_cur}, exp_sel(3));
    send_bits(8'h4D, 3, 7);
    chk("auto_vld", {7'd0, o_vld}, 8'd1);
    chk("auto_sel_wrap", {5'd0, o_sel_cur}, exp_sel(0));
    @(posedge clk); #1;
    chk("auto_vld_one_cycle", {7'd0, o_vld}, 8'd0);

    // Explicit mode with a rewrite of index 3: only bit 5 survives.
    exp_q.push_back(8'h20);
    strobe(1'b0, 1'b0, 3'd7);
    strobe(1'b0, 1'b0, 3'd6);
    strobe(1'b1, 1'b0, 3'd5);
    strobe(1'b0, 1'b0, 3'd4);
    strobe(1'b1, 1'b0, 3'd3);
    strobe(1'b0, 1'b0, 3'd3);
    strobe(1'b0, 1'b0, 3'd2);
    strobe(1'b0, 1'b0, 3'd1);
    chk("expl_no_early", {7'd0, o_vld}, 8'd0);
    chk("expl_sel_held", {5'd0, o_sel_cur}, exp_sel(0));
    strobe(1'b0, 1'b0, 3'd0);
    chk("expl_vld", {7'd0, o_vld}, 8'd1);
    @(posedge clk); #1;

    // Backpressure: A5 held, 3C dropped.
    i_rdy = 1'b0;
    exp_q.push_back(8'hA5);
    send_bits(8'hA5, 0, 7);
    chk("bp_first_ovf", {7'd0, o_ovf}, 8'd0);
    send_bits(8'h3C, 0, 7);
    chk("bp_code_held", o_code, 8'hA5);
    chk("bp_ovf", {7'd0, o_ovf}, 8'd1);
    chk("bp_vld", {7'd0, o_vld}, 8'd1);
    i_rdy = 1'b1;
    @(posedge clk); #1;
    chk("bp_vld_fall", {7'd0, o_vld}, 8'd0);
    chk("bp_ovf_sticky", {7'd0, o_ovf}, 8'd1);

    // Completion coincides with the consumer taking the held word.
    do_reset();
    exp_q.push_back(8'h11);
    send_bits(8'h11, 0, 7);
    send_bits(8'h22, 0, 6);
    chk("sim_hold", o_code, 8'h11);
    i_rdy = 1'b1;
    exp_q.push_back(8'h22);
    send_bits(8'h22, 7, 7);
    chk("sim_code", o_code, 8'h22);
    chk("sim_vld", {7'd0, o_vld}, 8'd1);
    chk("sim_ovf", {7'd0, o_ovf}, 8'd0);
    @(posedge clk); #1;
    chk("sim_vld_fall", {7'd0, o_vld}, 8'd0);

    // Disabled strobes must leave mask, counter and shadow untouched.
    exp_q.push_back(8'h96);
    send_bits(8'h96, 0, 2);
    i_en = 1'b0;
    for (int k = 0; k < 5; k++) strobe(1'b1, 1'b0, 3'(3 + k));
    chk("en_sel_held", {5'd0, o_sel_cur}, exp_sel(3));
    chk("en_no_vld", {7'd0, o_vld}, 8'd0);
    i_en = 1'b1;
    send_bits(8'h96, 3, 6);
    chk("en_no_early", {7'd0, o_vld}, 8'd0);
    send_bits(8'h96, 7, 7);
    chk("en_vld", {7'd0, o_vld}, 8'd1);
    @(posedge clk); #1;

    // Async reset during HOLD with a partial word in flight.
    i_rdy = 1'b0;
    send_bits(8'h5A, 0, 7);
    chk("ar_hold_code", o_code, 8'h5A);
    send_bits(8'hFF, 0, 3);
    #2 i_rst_n = 1'b0;
    #1;
    chk("ar_code", o_code, 8'h00);
    chk("ar_vld", {7'd0, o_vld}, 8'd0);
    chk("ar_sel", {5'd0, o_sel_cur}, exp_sel(0));
    chk("ar_ovf", {7'd0, o_ovf}, 8'd0);
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    i_rdy = 1'b1;
    exp_q.push_back(8'h3C);
    send_bits(8'h3C, 0, 6);
    chk("ar_fresh_no_early", {7'd0, o_vld}, 8'd0);
    send_bits(8'h3C, 7, 7);
    chk("ar_fresh_vld", {7'd0, o_vld}, 8'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 8'(exp_q.size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
